running_low_pipelined: RTL and testbench
========================================

RUNNING_LOW_PIPELINED -- requirements
Module: running_low_pipelined

Interface
REQ-001 Parameter DEPTH, default 8: window length in samples; SHALL be a power of two, >= 2.
REQ-002 Parameter WIDTH, default 4: sample width in bits, unsigned.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
REQ-005 in_valid  input  1  data_in is accepted on any rising edge where this is high; there is no backpressure.
REQ-006 data_in  input  WIDTH  sample value.
REQ-007 clear  input  1  synchronous window flush without a full reset.
REQ-008 low_out  output  WIDTH  minimum of the window, registered.
REQ-009 low_valid  output  1  one-cycle pulse; low_out is valid for exactly one accepted sample.
REQ-010 window_full  output  1  high while the window holds DEPTH samples.

Function
REQ-011 Window SHALL be a DEPTH-entry shift register that shifts only on accepted samples; the newest sample enters entry 0 and the oldest is discarded.
REQ-012 Fill counter SHALL increment per accepted sample, saturate at DEPTH, and drive window_full = (count == DEPTH).
REQ-013 Entries not yet filled SHALL present all-ones (2^WIDTH-1) to the comparator tree, so they never lower the minimum.
REQ-014 Minimum SHALL be computed by a binary tree of log2(DEPTH) compare levels, each level registered; ties pass the equal value.
REQ-015 A valid tag SHALL travel alongside each tree level; low_valid SHALL be the tag at the output register.
REQ-016 Latency: sample accepted at the edge ending cycle c -> low_valid high and low_out reflecting a window that includes it in cycle c+1+log2(DEPTH) (cycle c+4 for DEPTH=8).
REQ-017 Back-to-back accepted samples SHALL yield back-to-back low_valid pulses, one per sample, in order; throughput is 1 sample/cycle.
REQ-018 clear alone SHALL set every entry to the unfilled state, zero the count, and kill all in-flight valid tags, so no low_valid pulses come from earlier samples.
REQ-019 clear with in_valid in the same cycle SHALL flush the window and then load data_in as the only entry, with count = 1 and its result valid at the normal latency.
REQ-020 low_out SHALL hold its last value when low_valid is low.

Reset
REQ-021 reset low at an edge: entries set to unfilled, count = 0, all valid tags = 0, low_out = 0, low_valid = 0, window_full = 0.
REQ-022 reset SHALL take priority over clear and in_valid, including when asserted mid-stream with results in flight.

Structure
REQ-023 Shared package running_pkg SHALL hold the default DEPTH/WIDTH constants and a LEVELS = log2(DEPTH) helper.
REQ-024 One registered compare level SHALL be the sub-module min_tree_stage (parameters: lane count, WIDTH; carries the valid tag); the top SHALL instantiate log2(DEPTH) of these.

Verification (DEPTH=8, WIDTH=4)
REQ-025 Reset, then samples 9,5,7 on consecutive cycles -> low_valid in cycles c+4..c+6 with low_out 9,5,5; window_full = 0.
REQ-026 Feed 8 samples 3,8,8,8,8,8,8,8, then 8 -> window_full rises after the 8th sample; the 9th result is 8 because 3 has aged out.
REQ-027 Gapped in_valid (one sample every 3 cycles) -> exactly one low_valid per sample, each at latency 4, with no extra pulses.
REQ-028 Window holding 2,6,6; assert clear with 2 results in flight -> no low_valid afterward; next sample 12 -> low_out 12.
REQ-029 clear and in_valid together with data_in 15 on a full window of zeros -> result 15, count = 1.
REQ-030 reset low mid-stream -> all outputs 0 on the next cycle; no stale pulses after reset is released.

Source files
------------

// File: rtl/running_pkg.sv
// running_pkg
//   Shared constants and helpers for the running-minimum block.
//   DEFAULT_DEPTH / DEFAULT_WIDTH : default window length and sample width.
//   levels(depth)                 : number of compare levels in the min tree.
package running_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 4;

  // Binary min tree over a power-of-two window needs log2(depth) levels.
  function automatic int levels(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/min_tree_stage.sv
// min_tree_stage
//   One registered level of the minimum tree. Reduces LANES input lanes to
//   LANES/2 output lanes by pairwise minimum and carries a valid tag with the
//   data.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-low reset
//   flush     : kills the valid tag at this edge (window clear)
//   in_valid  : tag for in_data
//   in_data   : LANES lanes of WIDTH bits, lane 0 at the LSBs
//   out_valid : registered tag
//   out_data  : LANES/2 lanes of registered pairwise minima
// Handshake: a lane set is transferred whenever in_valid is high at a rising
// edge; there is no ready, so every stage accepts unconditionally.
module min_tree_stage #(
  parameter int LANES = 8,
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [LANES*WIDTH-1:0]       in_data,
  output logic                         out_valid,
  output logic [(LANES/2)*WIDTH-1:0]   out_data
);

  localparam int OUT_LANES = LANES / 2;

  logic [OUT_LANES*WIDTH-1:0] min_data;

  // Pairwise minimum; on a tie lane 2i passes, which is the same value.
  always_comb begin
    min_data = '0;
    for (int i = 0; i < OUT_LANES; i++) begin
      if (in_data[(2*i+1)*WIDTH +: WIDTH] < in_data[(2*i)*WIDTH +: WIDTH])
        min_data[i*WIDTH +: WIDTH] = in_data[(2*i+1)*WIDTH +: WIDTH];
      else
        min_data[i*WIDTH +: WIDTH] = in_data[(2*i)*WIDTH +: WIDTH];
    end
  end

  // Data only moves with a valid tag so the last stage holds its value
  // between results.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid && !flush;
      if (in_valid && !flush)
        out_data <= min_data;
    end
  end

endmodule

// File: rtl/running_low_pipelined.sv
// running_low_pipelined
//   Running minimum over the last DEPTH accepted samples. The window is a
//   shift register (entry 0 = newest); the minimum is produced by a fully
//   pipelined binary tree, one result per accepted sample, LEVELS+1 cycles
//   after acceptance.
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous active-low reset, highest priority
//   in_valid    : data_in accepted at this edge (no backpressure)
//   data_in     : sample, unsigned WIDTH bits
//   clear       : flush the window and in-flight results; with in_valid the
//                 new sample becomes the only entry
//   low_out     : registered window minimum, holds between results
//   low_valid   : one-cycle pulse per accepted sample
//   window_full : window holds DEPTH samples
module running_low_pipelined
  import running_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear,
  output logic [WIDTH-1:0] low_out,
  output logic             low_valid,
  output logic             window_full
);

  localparam int LEVELS = levels(DEPTH);
  localparam int NODES  = 2 * DEPTH - 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  // Unfilled entries hold all-ones so they never win the minimum.
  localparam logic [DEPTH*WIDTH-1:0] UNFILLED = '1;

  logic [DEPTH*WIDTH-1:0] window;
  logic [CNT_W-1:0]       count;
  logic                   win_valid;
  logic [LEVELS:0]        vld;
  // Every tree level packed back to back: level l starts at lane
  // 2*DEPTH - 2*(DEPTH>>l); level 0 is the window itself.
  logic [NODES*WIDTH-1:0] nodes;

  always_ff @(posedge clk) begin
    if (!reset) begin
      window    <= UNFILLED;
      count     <= '0;
      win_valid <= 1'b0;
    end else if (clear) begin
      if (in_valid) begin
        window <= {{((DEPTH-1)*WIDTH){1'b1}}, data_in};
        count  <= CNT_W'(1);
      end else begin
        window <= UNFILLED;
        count  <= '0;
      end
      win_valid <= in_valid;
    end else begin
      if (in_valid) begin
        window <= {window[(DEPTH-1)*WIDTH-1:0], data_in};
        if (count != CNT_W'(DEPTH))
          count <= count + CNT_W'(1);
      end
      win_valid <= in_valid;
    end
  end

  assign nodes[DEPTH*WIDTH-1:0] = window;
  assign vld[0] = win_valid;

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int LANES   = DEPTH >> l;
    localparam int IN_OFF  = 2 * DEPTH - 2 * LANES;
    localparam int OUT_OFF = 2 * DEPTH - LANES;

    min_tree_stage #(
      .LANES (LANES),
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (clear),
      .in_valid  (vld[l]),
      .in_data   (nodes[IN_OFF*WIDTH +: LANES*WIDTH]),
      .out_valid (vld[l+1]),
      .out_data  (nodes[OUT_OFF*WIDTH +: (LANES/2)*WIDTH])
    );
  end

  assign low_out     = nodes[NODES*WIDTH-1 -: WIDTH];
  assign low_valid   = vld[LEVELS];
  assign window_full = (count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_running_low_pipelined.sv
module tb_running_low_pipelined;

  localparam int DEPTH = 8;
  localparam int WIDTH = 4;
  localparam int LAT   = $clog2(DEPTH);  // edges from window load to output

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] data_in;
  logic             clear;
  logic [WIDTH-1:0] low_out;
  logic             low_valid;
  logic             window_full;

  always #5 clk = ~clk;

  running_low_pipelined #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .clear       (clear),
    .low_out     (low_out),
    .low_valid   (low_valid),
    .window_full (window_full)
  );

  // ---------------- reference model / scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  logic [WIDTH-1:0] win_q[$];   // accepted samples, newest at front
  logic [WIDTH-1:0] exp_q[$];   // expected minima in order
  int               due_q[$];   // edge number at which each becomes visible
  logic             exp_valid;
  logic [WIDTH-1:0] exp_low;
  logic             exp_full;

  // Drive one cycle, then update the model for the edge just taken.
  task automatic step(input logic v, input logic [WIDTH-1:0] d,
                      input logic c, input logic r);
    logic [WIDTH-1:0] m;
    in_valid = v;
    data_in  = d;
    clear    = c;
    reset    = r;
    @(posedge clk);
    #1;
    edge_n++;
    if (!r) begin
      win_q.delete();
      exp_q.delete();
      due_q.delete();
      exp_low = '0;
    end else begin
      if (c) begin
        win_q.delete();
        exp_q.delete();
        due_q.delete();
      end
      if (v) begin
        win_q.push_front(d);
        if (win_q.size() > DEPTH) void'(win_q.pop_back());
        m = '1;
        foreach (win_q[i]) if (win_q[i] < m) m = win_q[i];
        exp_q.push_back(m);
        due_q.push_back(edge_n + LAT);
      end
    end
    exp_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] == edge_n) begin
      exp_valid = 1'b1;
      exp_low   = exp_q.pop_front();
      void'(due_q.pop_front());
    end
    exp_full = (win_q.size() == DEPTH);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'd3, 1'b0, 1'b0);
      checks++; if (low_valid !== 1'b0) begin failures++; $display("FAIL reset low_valid got=%b exp=0", low_valid); end
      checks++; if (low_out !== '0) begin failures++; $display("FAIL reset low_out got=%0d exp=0", low_out); end
      checks++; if (window_full !== 1'b0) begin failures++; $display("FAIL reset window_full got=%b exp=0", window_full); end
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] want [3];
    want[0] = 4'd9; want[1] = 4'd5; want[2] = 4'd5;
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: step(1'b1, 4'd9, 1'b0, 1'b1);
        1: step(1'b1, 4'd5, 1'b0, 1'b1);
        2: step(1'b1, 4'd7, 1'b0, 1'b1);
        default: step(1'b0, '0, 1'b0, 1'b1);
      endcase
      if (low_valid === 1'b1) got.push_back(low_out);
      checks++; if (low_valid !== exp_valid) begin failures++; $display("FAIL basic low_valid edge=%0d got=%b exp=%b", edge_n, low_valid, exp_valid); end
      checks++; if (low_out !== exp_low) begin failures++; $display("FAIL basic low_out edge=%0d got=%0d exp=%0d", edge_n, low_out, exp_low); end
      checks++; if (window_full !== 1'b0) begin failures++; $display("FAIL basic window_full edge=%0d got=%b exp=0", edge_n, window_full); end
    end
    checks++; if (got.size() != 3) begin failures++; $display("FAIL basic pulse_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== want[i]) begin failures++; $display("FAIL basic result%0d got=%0d exp=%0d", i, got[i], want[i]); end
    end
  endtask

  task automatic test_age_out();
    logic [WIDTH-1:0] last;
    last = '0;
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 9 + LAT + 1; i++) begin
      if (i == 0) step(1'b1, 4'd3, 1'b0, 1'b1);
      else if (i < 9) step(1'b1, 4'd8, 1'b0, 1'b1);
      else step(1'b0, '0, 1'b0, 1'b1);
      if (low_valid === 1'b1) last = low_out;
      if (i == 6) begin
        checks++; if (window_full !== 1'b0) begin failures++; $display("FAIL age_out full_after7 got=%b exp=0", window_full); end
      end
      if (i == 7) begin
        checks++; if (window_full !== 1'b1) begin failures++; $display("FAIL age_out full_after8 got=%b exp=1", window_full); end
      end
      checks++; if (low_valid !== exp_valid) begin failures++; $display("FAIL age_out low_valid edge=%0d got=%b exp=%b", edge_n, low_valid, exp_valid); end
      checks++; if (low_out !== exp_low) begin failures++; $display("FAIL age_out low_out edge=%0d got=%0d exp=%0d", edge_n, low_out, exp_low); end
      checks++; if (window_full !== exp_full) begin failures++; $display("FAIL age_out window_full edge=%0d got=%b exp=%b", edge_n, window_full, exp_full); end
    end
    checks++; if (last !== 4'd8) begin failures++; $display("FAIL age_out ninth_result got=%0d exp=8", last); end
  endtask

  task automatic test_gapped();
    int pulses;
    int samples;
    pulses  = 0;
    samples = 0;
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 36; i++) begin
      if (i % 3 == 0 && i < 30) begin
        step(1'b1, WIDTH'($urandom_range(0, 15)), 1'b0, 1'b1);
        samples++;
      end else begin
        step(1'b0, WIDTH'($urandom_range(0, 15)), 1'b0, 1'b1);
      end
      if (low_valid === 1'b1) pulses++;
      checks++; if (low_valid !== exp_valid) begin failures++; $display("FAIL gapped low_valid edge=%0d got=%b exp=%b", edge_n, low_valid, exp_valid); end
      checks++; if (low_out !== exp_low) begin failures++; $display("FAIL gapped low_out edge=%0d got=%0d exp=%0d", edge_n, low_out, exp_low); end
      checks++; if (window_full !== exp_full) begin failures++; $display("FAIL gapped window_full edge=%0d got=%b exp=%b", edge_n, window_full, exp_full); end
    end
    checks++; if (pulses != samples) begin failures++; $display("FAIL gapped pulse_count got=%0d exp=%0d", pulses, samples); end
  endtask

  task automatic test_clear_inflight();
    logic [WIDTH-1:0] last;
    last = '0;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 4'd2, 1'b0, 1'b1);
    step(1'b1, 4'd6, 1'b0, 1'b1);
    step(1'b1, 4'd6, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);   // first result leaves, two still in flight
    step(1'b0, '0, 1'b1, 1'b1);   // clear
    checks++; if (low_valid !== 1'b0) begin failures++; $display("FAIL clear_inflight pulse_at_clear got=%b exp=0", low_valid); end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (low_valid !== 1'b0) begin failures++; $display("FAIL clear_inflight stale_pulse edge=%0d got=%b exp=0", edge_n, low_valid); end
      checks++; if (window_full !== exp_full) begin failures++; $display("FAIL clear_inflight window_full edge=%0d got=%b exp=%b", edge_n, window_full, exp_full); end
    end
    step(1'b1, 4'd12, 1'b0, 1'b1);
    for (int i = 0; i < LAT + 1; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (low_valid === 1'b1) last = low_out;
      checks++; if (low_valid !== exp_valid) begin failures++; $display("FAIL clear_inflight low_valid edge=%0d got=%b exp=%b", edge_n, low_valid, exp_valid); end
    end
    checks++; if (last !== 4'd12) begin failures++; $display("FAIL clear_inflight after_clear got=%0d exp=12", last); end
  endtask

  task automatic test_clear_load();
    logic [WIDTH-1:0] last;
    last = '0;
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 4'd0, 1'b0, 1'b1);
    checks++; if (window_full !== 1'b1) begin failures++; $display("FAIL clear_load full_of_zeros got=%b exp=1", window_full); end
    step(1'b1, 4'd15, 1'b1, 1'b1);
    checks++; if (window_full !== 1'b0) begin failures++; $display("FAIL clear_load full_after_clear got=%b exp=0", window_full); end
    for (int i = 0; i < LAT + 1; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (low_valid === 1'b1) last = low_out;
      checks++; if (low_valid !== exp_valid) begin failures++; $display("FAIL clear_load low_valid edge=%0d got=%b exp=%b", edge_n, low_valid, exp_valid); end
      checks++; if (low_out !== exp_low) begin failures++; $display("FAIL clear_load low_out edge=%0d got=%0d exp=%0d", edge_n, low_out, exp_low); end
    end
    checks++; if (last !== 4'd15) begin failures++; $display("FAIL clear_load result got=%0d exp=15", last); end
    // count restarted at 1: seven more samples must fill the window exactly
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(1'b1, WIDTH'($urandom_range(0, 15)), 1'b0, 1'b1);
      checks++; if (window_full !== exp_full) begin failures++; $display("FAIL clear_load refill edge=%0d got=%b exp=%b", edge_n, window_full, exp_full); end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 10; i++) step(1'b1, WIDTH'($urandom_range(0, 15)), 1'b0, 1'b1);
    step(1'b1, 4'd1, 1'b1, 1'b0);
    checks++; if (low_valid !== 1'b0) begin failures++; $display("FAIL reset_mid low_valid got=%b exp=0", low_valid); end
    checks++; if (low_out !== '0) begin failures++; $display("FAIL reset_mid low_out got=%0d exp=0", low_out); end
    checks++; if (window_full !== 1'b0) begin failures++; $display("FAIL reset_mid window_full got=%b exp=0", window_full); end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (low_valid !== 1'b0) begin failures++; $display("FAIL reset_mid stale_pulse edge=%0d got=%b exp=0", edge_n, low_valid); end
      checks++; if (low_out !== '0) begin failures++; $display("FAIL reset_mid low_out_hold edge=%0d got=%0d exp=0", edge_n, low_out); end
    end
  endtask

  task automatic test_back_to_back_random();
    logic v;
    logic c;
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 39) == 0);
      step(v, WIDTH'($urandom_range(0, 15)), c, 1'b1);
      checks++; if (low_valid !== exp_valid) begin failures++; $display("FAIL random low_valid edge=%0d got=%b exp=%b", edge_n, low_valid, exp_valid); end
      checks++; if (low_out !== exp_low) begin failures++; $display("FAIL random low_out edge=%0d got=%0d exp=%0d", edge_n, low_out, exp_low); end
      checks++; if (window_full !== exp_full) begin failures++; $display("FAIL random window_full edge=%0d got=%b exp=%b", edge_n, window_full, exp_full); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    clear    = 1'b0;
    exp_valid = 1'b0;
    exp_low   = '0;
    exp_full  = 1'b0;
    test_reset();
    test_basic();
    test_age_out();
    test_gapped();
    test_clear_inflight();
    test_clear_load();
    test_reset_midstream();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
